// File: rtl/noc_pkt_pkg.sv
// Shared types and header field layout for the NoC output-side packetizer.
package noc_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int HDR_DEST_LSB = 24;
    localparam int HDR_SRC_LSB  = 16;
    localparam int HDR_LEN_LSB  = 12;
    localparam int HDR_OFF_LSB  = 0;

    // Fields arrive zero-extended to 32 bits; dest_y sits directly above dest_x.
    function automatic logic [31:0] build_header(
        input logic [31:0] dest_y,
        input logic [31:0] dest_x,
        input logic [31:0] src,
        input logic [31:0] len,
        input logic [31:0] offset,
        input int          xy_sz
    );
        return (dest_y << (HDR_DEST_LSB + xy_sz))
             | (dest_x << HDR_DEST_LSB)
             | (src    << HDR_SRC_LSB)
             | (len    << HDR_LEN_LSB)
             | (offset << HDR_OFF_LSB);
    endfunction

endpackage

// File: rtl/noc_pld_fifo.sv
// Payload FIFO: 32-bit words, registered write, head visible the cycle after the write.
module noc_pld_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_line,
    input  logic                     clk_line_rst_low,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              din,
    output logic [31:0]              dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_line) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/noc_pkt_tx.sv
// NoC packetizer: one header beat, then cmd_len+1 payload beats from the FIFO, TLAST on the last.
module noc_pkt_tx
    import noc_pkt_pkg::*;
#(
    parameter int XY_SZ      = 4,
    parameter int OFFSET_SZ  = 12,
    parameter int LEN_SZ     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_low,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [XY_SZ-1:0]     cmd_dest_x,
    input  logic [XY_SZ-1:0]     cmd_dest_y,
    input  logic [OFFSET_SZ-1:0] cmd_offset,
    input  logic [LEN_SZ-1:0]    cmd_len,
    input  logic                 pld_valid,
    output logic                 pld_ready,
    input  logic [31:0]          pld_data,
    input  logic                 stream_out_TREADY,
    output logic                 stream_out_TVALID,
    output logic [31:0]          stream_out_TDATA,
    output logic [3:0]           stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    output logic                 busy,
    output logic [15:0]          pkt_count
);
    generate
        if (4 * XY_SZ + LEN_SZ + OFFSET_SZ != 32) begin : g_bad_width
            $error("noc_pkt_tx: 4*XY_SZ + LEN_SZ + OFFSET_SZ must equal 32");
        end
        if (OFFSET_SZ != HDR_LEN_LSB || LEN_SZ != HDR_SRC_LSB - HDR_LEN_LSB) begin : g_bad_layout
            $error("noc_pkt_tx: field widths do not match the header bit positions");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("noc_pkt_tx: FIFO_DEPTH must be a power of 2");
        end
    endgenerate

    state_t                    r_state;
    logic [31:0]               r_hdr;
    logic [LEN_SZ-1:0]         r_len;
    logic [LEN_SZ-1:0]         r_cnt;
    logic [15:0]               r_pkt_count;
    logic                      r_live;

    logic                      w_push;
    logic                      w_pop;
    logic [31:0]               w_fifo_dout;
    logic                      w_empty;
    logic                      w_full;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                      w_in_hdr;
    logic                      w_data_valid;
    logic                      w_last;
    logic                      w_cmd_fire;

    noc_pld_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_line         (clk_line),
        .clk_line_rst_low (clk_line_rst_low),
        .push             (w_push),
        .pop              (w_pop),
        .din              (pld_data),
        .dout             (w_fifo_dout),
        .empty            (w_empty),
        .full             (w_full),
        .count            (w_count)
    );

    // r_live keeps the ready outputs low while reset is held and until the first edge after release.
    assign cmd_ready    = r_live & (r_state == IDLE);
    assign pld_ready    = r_live & ~w_full;
    assign w_push       = pld_valid & pld_ready;
    assign w_cmd_fire   = cmd_valid & cmd_ready;

    assign w_in_hdr     = (r_state == HDR);
    assign w_data_valid = (r_state == DATA) & ~w_empty;
    assign w_last       = w_data_valid & (r_cnt == r_len);
    assign w_pop        = w_data_valid & stream_out_TREADY;

    assign stream_out_TVALID = w_in_hdr | w_data_valid;
    assign stream_out_TDATA  = w_in_hdr ? r_hdr : (w_data_valid ? w_fifo_dout : 32'h0);
    assign stream_out_TKEEP  = {4{stream_out_TVALID}};
    assign stream_out_TLAST  = w_last;
    assign busy              = (r_state != IDLE);
    assign pkt_count         = r_pkt_count;

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            r_state     <= IDLE;
            r_hdr       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_pkt_count <= '0;
            r_live      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_hdr   <= build_header(32'(cmd_dest_y), 32'(cmd_dest_x), 32'(HsrcId),
                                                32'(cmd_len), 32'(cmd_offset), XY_SZ);
                        r_len   <= cmd_len;
                        r_cnt   <= '0;
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (stream_out_TREADY) r_state <= DATA;
                end
                DATA: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state     <= IDLE;
                            r_pkt_count <= r_pkt_count + 16'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/noc_pkt_tx.md
Name: noc_pkt_tx

Overview:
- Output-side NoC packetizer for accelerator tiles. Sits between the tile's ACC logic and the tile stream_out AXI-Stream port toward the NoC router.
- Input side: a command (destination X/Y, offset, length) plus a stream of payload words, which are buffered in an internal FIFO.
- Output side: one header beat followed by length+1 payload beats, with TLAST on the final beat.
- Counterpart to the input-side buffer that feeds ACC logic from stream_in.

Parameters:
- XY_SZ, 4: width of each X/Y coordinate.
- OFFSET_SZ, 12: width of the header offset field.
- LEN_SZ, 4: width of the length field. Packet payload = cmd_len+1 words.
- FIFO_DEPTH, 8: payload FIFO entries. Must be a power of 2.
- Constraint: 4*XY_SZ + LEN_SZ + OFFSET_SZ == 32 (checked by elaboration assertion).

Ports:
- clk_line  in  1  sole clock
- clk_line_rst_low  in  1  asynchronous active-low reset
- HsrcId  in  2*XY_SZ  source tile ID {y,x}
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_dest_x  in  XY_SZ  destination X
- cmd_dest_y  in  XY_SZ  destination Y
- cmd_offset  in  OFFSET_SZ  header offset field
- cmd_len  in  LEN_SZ  payload words minus 1
- pld_valid  in  1  payload word valid
- pld_ready  out  1  FIFO can accept a word
- pld_data  in  32  payload word
- stream_out_TREADY  in  1  NoC ready
- stream_out_TVALID  out  1  beat valid
- stream_out_TDATA  out  32  beat data
- stream_out_TKEEP  out  4  byte enables
- stream_out_TLAST  out  1  last beat of packet
- busy  out  1  FSM not in IDLE
- pkt_count  out  16  completed packets, wraps modulo 2^16

Behaviour:
- Reset (asynchronous, active-low):
  - FSM returns to IDLE. FIFO pointers and count are cleared. pkt_count = 0.
  - All outputs are 0 while reset is asserted: TVALID, TDATA, TKEEP, TLAST, cmd_ready, pld_ready, busy.
  - An in-flight packet is truncated; no TLAST is emitted. Downstream recovery is out of scope.
- Header layout:
  - [31:24] = {dest_y, dest_x}
  - [23:16] = HsrcId, sampled when the command is accepted
  - [15:12] = cmd_len
  - [11:0] = cmd_offset
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the command fields and HsrcId, clear the beat counter, and move to HDR on the next cycle.
- HDR:
  - TVALID = 1, TDATA = latched header, TLAST = 0.
  - On TREADY, move to DATA.
  - The header is sent even if the FIFO is empty.
- DATA:
  - TVALID = FIFO not empty. TDATA = FIFO head. TLAST = TVALID & (cnt == len).
  - On a handshake: pop the FIFO and increment cnt.
  - If TLAST is handshaken: go to IDLE and increment pkt_count. cmd_ready rises in the following cycle (minimum one-cycle gap between packets).
- AXI-Stream rules:
  - Once TVALID is high, TDATA, TKEEP and TLAST stay stable until TREADY.
  - TVALID never depends combinationally on TREADY.
  - TKEEP = 4'hF when TVALID = 1, else 4'h0.
- Payload FIFO:
  - pld_ready = !full. A word is written on pld_valid & pld_ready and becomes visible at the head on the next cycle (no fall-through).
  - Push and pop in the same cycle: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Payload may be pushed in any state, including before its command, so it can pre-fill for the next packet.
  - The FIFO is not flushed between packets.
- Latency: accepted command to header TVALID is 1 cycle. With ready sink and pre-filled FIFO, header plus N words take N+1 consecutive cycles.
- Stalls: if the FIFO runs empty mid-packet, TVALID drops between beats. There is no timeout.
- Payload count integrity is the producer's responsibility; excess words carry over into the next packet.
- busy = (state != IDLE).

Decomposition:
- Package noc_pkt_pkg:
  - state enum {IDLE, HDR, DATA}
  - header field bit-position localparams: HDR_DEST_LSB = 24, HDR_SRC_LSB = 16, HDR_LEN_LSB = 12, HDR_OFF_LSB = 0
  - helper function build_header(dest_y, dest_x, src, len, offset)
- Sub-module noc_pld_fifo:
  - synchronous FIFO: 32-bit data, depth FIFO_DEPTH, same clock and reset
  - ports: push, pop, din, dout, empty, full, count

Test Plan:
1. Pre-load 32'hDEADBEEF; command dest_x = 2, dest_y = 3, HsrcId = 8'h11, offset = 12'h040, len = 0; TREADY = 1 -> beats 32'h32110040 (TLAST = 0) then 32'hDEADBEEF (TLAST = 1), TKEEP = 4'hF; pkt_count = 1.
2. Pre-load words 1..4, len = 3, TREADY toggling every cycle -> 5 beats in order, TDATA stable across stalls, TLAST only on word 4.
3. Command len = 2 with FIFO empty -> header sent; TVALID low until push; words A, B, C pushed 3 cycles apart each appear one cycle after push; TLAST on C.
4. TREADY = 0, push 9 words -> pld_ready = 0 after the 8th push; 9th not accepted; after one pop, pld_ready = 1 the next cycle.
5. Two commands held back-to-back with 2 words each pre-loaded -> cmd_ready = 1 one cycle after the first TLAST handshake; second header follows; pkt_count = 2.
6. Assert reset during DATA after 1 of 4 words -> all outputs 0 immediately; busy = 0, FIFO empty, pkt_count = 0; cmd_ready = 1 on the first edge after release.
